cfg_cmd_decoder: RTL and testbench
==================================

Name: cfg_cmd_decoder

Overview:
- Byte-stream command frame decoder. It is the initiator that drives the ConfigReg write port (wr / wr_addr / data).
- Sits between the ground-link byte receiver (UART/serial deserialiser) and the configuration register bank.
- Validates the frame header and checksum, then issues exactly one single-cycle register write per valid frame.
- Exports frame-good and frame-error counters for housekeeping.

Parameters:
HDR0, 8'hEB, first sync byte
HDR1, 8'h90, second sync byte
TIMEOUT_CYC, 16'd5000, idle clocks allowed between bytes inside a frame (100 us at 50 MHz)
ADDR_MIN, 8'h02, lowest writable address (used only with CFG_ADDR_CHECK_EN)
ADDR_MAX, 8'h15, highest writable address (used only with CFG_ADDR_CHECK_EN)

Ports:
clk_in  input  1  system clock, 50 MHz
rst_n_in  input  1  asynchronous active-low reset
byte_in  input  8  received byte, valid when byte_vld_in=1
byte_vld_in  input  1  one-cycle strobe per received byte
wr_out  output  1  one-cycle write strobe to the config register bank
wr_addr_out  output  8  write address; stable from the wr_out cycle until the next write
data_out  output  16  write data, MSB byte first on the link; stable as for wr_out
frame_ok_cnt_out  output  16  count of accepted frames, wraps at 16'hFFFF->0
frame_err_cnt_out  output  16  count of checksum, timeout and address errors; saturates at 16'hFFFF
busy_out  output  1  high while the FSM is outside IDLE

Behaviour:
- Reset (asynchronous, rst_n_in=0):
  - FSM goes to IDLE.
  - All outputs 0; the timeout counter is cleared.
  - Reset asserted mid-frame discards the partial frame. It issues no write and counts no error.
- Frame format: HDR0, HDR1, ADDR, DHI, DLO, CSUM.
  - CSUM = (ADDR + DHI + DLO) mod 256.
- FSM states: IDLE, SYNC, ADDR, DHI, DLO, CSUM.
  - A transition happens only on a clock edge where byte_vld_in=1, except on timeout.
- State transitions:
  - IDLE: byte==HDR0 -> SYNC; any other byte stays in IDLE.
  - SYNC: byte==HDR1 -> ADDR; byte==HDR0 stays in SYNC (resync); else -> IDLE. No error is counted for sync hunting.
  - ADDR: latch the byte into the address shadow -> DHI.
  - DHI: latch into data[15:8] -> DLO.
  - DLO: latch into data[7:0] -> CSUM.
  - CSUM, checksum match: -> IDLE. Shadow values are copied to wr_addr_out/data_out, and wr_out=1 in the next cycle only. frame_ok_cnt increments in that same cycle.
  - CSUM, checksum mismatch: -> IDLE. No write; frame_err_cnt increments.
- Write latency: wr_out rises 1 clock after the edge that samples CSUM. Pulse width is exactly 1 cycle.
- Back-to-back frames: a byte_vld_in in the wr_out cycle is processed by IDLE normally. There is no dead time.
- Timeout:
  - In SYNC through CSUM, the counter increments on every clock without byte_vld_in and clears on byte_vld_in.
  - At count==TIMEOUT_CYC-1 the FSM returns to IDLE and frame_err_cnt increments.
  - A byte arriving on that same edge takes priority: the counter clears and the FSM advances.
- wr_addr_out and data_out change only when a write is issued; partial frames never disturb them.
- The error counter saturates and the ok counter wraps.
- busy_out is the registered value of (state != IDLE).

Optional Feature:
- Macro: CFG_ADDR_CHECK_EN.
- When defined: at CSUM, a frame whose ADDR is outside ADDR_MIN..ADDR_MAX (inclusive) is rejected even if its checksum is correct. It issues no write and frame_err_cnt increments.
- When not defined: every checksum-valid frame is written regardless of address.

Decomposition:
- Shared package cfg_link_pkg holds:
  - HDR0/HDR1 defaults;
  - state encoding localparams;
  - ADDR_MIN/ADDR_MAX defaults, kept consistent with the ConfigReg address map 8'h02..8'h15;
  - the checksum width.
- One natural sub-module: cfg_byte_timeout (gap counter with clear/expire). Everything else stays flat.

Test Plan:
- Frame EB 90 02 00 01 03:
  - wr_out pulses for 1 cycle, 1 clock after the CSUM byte.
  - wr_addr_out=8'h02, data_out=16'h0001.
  - frame_ok_cnt_out=1.
- Frame EB 90 04 12 34 00 (correct CSUM is 4A): no wr_out; frame_err_cnt_out=1; wr_addr_out/data_out unchanged.
- Stream EB EB 90 03 00 55 58: SYNC resyncs on the second EB; a write of addr 8'h03, data 16'h0055 is issued.
- Stream EB 90 05 then 5000 idle clocks: FSM returns to IDLE, busy_out=0, frame_err_cnt_out=1, no write.
  - A following complete valid frame is accepted normally.
- Reset pulse after EB 90 06 12: all outputs 0, no write.
  - A subsequent EB 90 06 12 34 4C writes addr 06, data 1234.
- With CFG_ADDR_CHECK_EN, frame EB 90 30 00 00 30: no write, frame_err_cnt_out=1.
  - Without the macro, the same frame writes addr 30, data 0000.

Source files
------------

// File: rtl/cfg_link_pkg.sv
// Shared constants, FSM state encoding and helpers for the ground-link command decoder.
package cfg_link_pkg;

    // Frame sync bytes.
    localparam logic [7:0]  HDR0        = 8'hEB;
    localparam logic [7:0]  HDR1        = 8'h90;

    // Idle clocks tolerated between bytes inside a frame (100 us at 50 MHz).
    localparam logic [15:0] TIMEOUT_CYC = 16'd5000;

    // Writable window of the ConfigReg address map.
    localparam logic [7:0]  ADDR_MIN    = 8'h02;
    localparam logic [7:0]  ADDR_MAX    = 8'h15;

    localparam int unsigned CSUM_W      = 8;

    // State encoding.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SYNC = 3'd1;
    localparam logic [2:0] ST_ADDR = 3'd2;
    localparam logic [2:0] ST_DHI  = 3'd3;
    localparam logic [2:0] ST_DLO  = 3'd4;
    localparam logic [2:0] ST_CSUM = 3'd5;

    typedef enum logic [2:0] {
        StIdle = ST_IDLE,
        StSync = ST_SYNC,
        StAddr = ST_ADDR,
        StDhi  = ST_DHI,
        StDlo  = ST_DLO,
        StCsum = ST_CSUM
    } dec_state_e;

    // Frame checksum: modular sum of the payload bytes.
    function automatic logic [CSUM_W-1:0] frame_csum(input logic [7:0] addr,
                                                     input logic [7:0] dhi,
                                                     input logic [7:0] dlo);
        return addr + dhi + dlo;
    endfunction

    function automatic logic addr_in_range(input logic [7:0] addr);
        return (addr >= ADDR_MIN) && (addr <= ADDR_MAX);
    endfunction

endpackage

// File: rtl/cfg_cmd_decoder_if.sv
// Byte-stream input and ConfigReg write port of the command decoder.
// master: the decoder (consumes bytes, drives writes); slave: the link/register-bank side.
interface cfg_cmd_decoder_if;

    logic [7:0]  byte_in;
    logic        byte_vld_in;
    logic        wr_out;
    logic [7:0]  wr_addr_out;
    logic [15:0] data_out;

    modport master (
        input  byte_in,
        input  byte_vld_in,
        output wr_out,
        output wr_addr_out,
        output data_out
    );

    modport slave (
        output byte_in,
        output byte_vld_in,
        input  wr_out,
        input  wr_addr_out,
        input  data_out
    );

endinterface

// File: rtl/cfg_byte_timeout.sv
// Inter-byte gap counter: counts idle clocks while a frame is open, clears on every byte,
// and flags expiry on the idle edge where the count has reached TimeoutCyc-1.
module cfg_byte_timeout #(
    parameter logic [15:0] TimeoutCyc = 16'd5000
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic run_i,
    input  logic clr_i,
    output logic expire_o
);

    logic [15:0] cnt_q, cnt_d;

    // A byte on the expiry edge wins, so clr_i masks the expiry.
    assign expire_o = run_i && !clr_i && (cnt_q == TimeoutCyc - 16'd1);

    // Next gap count.
    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (!run_i || clr_i || expire_o) begin
            cnt_d = '0;
        end
    end

    // Gap count register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cfg_cmd_decoder.sv
// Command frame decoder: EB 90 ADDR DHI DLO CSUM -> one single-cycle ConfigReg write.
// Optional macro CFG_ADDR_CHECK_EN: reject checksum-valid frames whose address lies
// outside ADDR_MIN..ADDR_MAX.
module cfg_cmd_decoder
    import cfg_link_pkg::*;
#(
    parameter logic [7:0]  Hdr0       = HDR0,
    parameter logic [7:0]  Hdr1       = HDR1,
    parameter logic [15:0] TimeoutCyc = TIMEOUT_CYC
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    cfg_cmd_decoder_if.master link,
    output logic [15:0]       frame_ok_cnt_out,
    output logic [15:0]       frame_err_cnt_out,
    output logic              busy_out
);

    dec_state_e  state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  dhi_q, dhi_d;
    logic [7:0]  dlo_q, dlo_d;
    logic        wr_q, wr_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [15:0] data_q, data_d;
    logic [15:0] ok_q, ok_d;
    logic [15:0] err_q, err_d;
    logic        busy_q;
    logic        err_inc;
    logic        expire;
    logic        csum_ok;
    logic        addr_ok;

    cfg_byte_timeout #(
        .TimeoutCyc (TimeoutCyc)
    ) u_timeout (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .run_i    (state_q != StIdle),
        .clr_i    (link.byte_vld_in),
        .expire_o (expire)
    );

    assign csum_ok = (frame_csum(addr_q, dhi_q, dlo_q) == link.byte_in);

`ifdef CFG_ADDR_CHECK_EN
    assign addr_ok = addr_in_range(addr_q);
`else
    assign addr_ok = 1'b1;
`endif

    // Next-state, shadow capture, write issue and counter updates.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        dhi_d     = dhi_q;
        dlo_d     = dlo_q;
        wr_d      = 1'b0;
        wr_addr_d = wr_addr_q;
        data_d    = data_q;
        ok_d      = ok_q;
        err_d     = err_q;
        err_inc   = 1'b0;

        if (link.byte_vld_in) begin
            unique case (state_q)
                StIdle: if (link.byte_in == Hdr0) state_d = StSync;
                StSync: begin
                    // A repeated HDR0 keeps hunting in SYNC.
                    if (link.byte_in == Hdr1) begin
                        state_d = StAddr;
                    end else if (link.byte_in != Hdr0) begin
                        state_d = StIdle;
                    end
                end
                StAddr: begin
                    addr_d  = link.byte_in;
                    state_d = StDhi;
                end
                StDhi: begin
                    dhi_d   = link.byte_in;
                    state_d = StDlo;
                end
                StDlo: begin
                    dlo_d   = link.byte_in;
                    state_d = StCsum;
                end
                StCsum: begin
                    state_d = StIdle;
                    if (csum_ok && addr_ok) begin
                        wr_d      = 1'b1;
                        wr_addr_d = addr_q;
                        data_d    = {dhi_q, dlo_q};
                        ok_d      = ok_q + 16'd1;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if (expire) begin
            state_d = StIdle;
            err_inc = 1'b1;
        end

        // Error counter saturates rather than wrapping.
        if (err_inc && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
        end
    end

    // State, shadow and output registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            dhi_q     <= '0;
            dlo_q     <= '0;
            wr_q      <= 1'b0;
            wr_addr_q <= '0;
            data_q    <= '0;
            ok_q      <= '0;
            err_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            dhi_q     <= dhi_d;
            dlo_q     <= dlo_d;
            wr_q      <= wr_d;
            wr_addr_q <= wr_addr_d;
            data_q    <= data_d;
            ok_q      <= ok_d;
            err_q     <= err_d;
            busy_q    <= (state_d != StIdle);
        end
    end

    assign link.wr_out       = wr_q;
    assign link.wr_addr_out  = wr_addr_q;
    assign link.data_out     = data_q;
    assign frame_ok_cnt_out  = ok_q;
    assign frame_err_cnt_out = err_q;
    assign busy_out          = busy_q;

endmodule

// File: tb/tb_cfg_cmd_decoder.sv
// Self-checking bench for cfg_cmd_decoder: directed frames plus randomized streams compared
// every cycle against a frame-level reference model.
module tb_cfg_cmd_decoder;

`ifdef CFG_ADDR_CHECK_EN
    localparam bit AddrChk = 1'b1;
`else
    localparam bit AddrChk = 1'b0;
`endif
    localparam int Timeout = 5000;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [15:0] ok_cnt;
    logic [15:0] err_cnt;
    logic        busy;

    cfg_cmd_decoder_if bus ();

    cfg_cmd_decoder dut (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
        .link              (bus),
        .frame_ok_cnt_out  (ok_cnt),
        .frame_err_cnt_out (err_cnt),
        .busy_out          (busy)
    );

    always #5 clk_in = ~clk_in;

    int n_total = 0;
    int n_bad   = 0;
    string phase = "init";

    // Reference model: bytes of the frame collected so far, and the idle gap.
    logic [7:0]  frm[$];
    int          gap;
    logic        m_wr;
    logic [7:0]  m_addr;
    logic [15:0] m_data;
    logic [15:0] m_ok;
    logic [15:0] m_err;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit tb_addr_ok(input logic [7:0] a);
        return !AddrChk || ((a >= 8'h02) && (a <= 8'h15));
    endfunction

    task automatic model_reset();
        frm.delete();
        gap    = 0;
        m_wr   = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_ok   = '0;
        m_err  = '0;
    endtask

    task automatic bump_err();
        if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
    endtask

    task automatic model_step(input logic v, input logic [7:0] b);
        logic [7:0] s;
        m_wr = 1'b0;
        if (v) begin
            gap = 0;
            if (frm.size() == 0) begin
                if (b == 8'hEB) frm.push_back(b);
            end else if (frm.size() == 1) begin
                if (b == 8'h90) frm.push_back(b);
                else if (b != 8'hEB) frm.delete();
            end else begin
                frm.push_back(b);
                if (frm.size() == 6) begin
                    s = frm[2] + frm[3] + frm[4];
                    if (s == frm[5] && tb_addr_ok(frm[2])) begin
                        m_wr   = 1'b1;
                        m_addr = frm[2];
                        m_data = {frm[3], frm[4]};
                        m_ok   = m_ok + 16'd1;
                    end else begin
                        bump_err();
                    end
                    frm.delete();
                end
            end
        end else if (frm.size() > 0) begin
            if (gap == Timeout - 1) begin
                frm.delete();
                gap = 0;
                bump_err();
            end else begin
                gap++;
            end
        end
    endtask

    function automatic logic [63:0] dut_vec();
        return {6'b0, bus.wr_out, bus.wr_addr_out, bus.data_out, ok_cnt, err_cnt, busy};
    endfunction

    function automatic logic [63:0] exp_vec();
        return {6'b0, m_wr, m_addr, m_data, m_ok, m_err, frm.size() > 0};
    endfunction

    // One clock: drive inputs, advance model at the edge, compare 1 ns later.
    task automatic tick(input logic v, input logic [7:0] b);
        bus.byte_vld_in = v;
        bus.byte_in     = b;
        @(posedge clk_in);
        model_step(v, b);
        #1;
        check_eq(phase, dut_vec(), exp_vec());
    endtask

    task automatic send(input logic [7:0] b);
        tick(1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'($urandom));
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [15:0] d, input logic [7:0] cs,
                              input int max_gap);
        logic [7:0] fb[6];
        fb = '{8'hEB, 8'h90, a, d[15:8], d[7:0], cs};
        for (int k = 0; k < 6; k++) begin
            send(fb[k]);
            if (k < 5) idle(int'($urandom_range(0, max_gap)));
        end
    endtask

    initial begin
        logic [7:0]  a;
        logic [15:0] d;
        logic [7:0]  cs;
        logic [7:0]  edge_addr[4];
        int          kind;

        model_reset();
        rst_n_in        = 1'b0;
        bus.byte_in     = '0;
        bus.byte_vld_in = 1'b0;
        #3;
        check_eq("reset_state", dut_vec(), 64'd0);
        repeat (2) @(posedge clk_in);
        #1 rst_n_in = 1'b1;

        phase = "f1";
        send_frame(8'h02, 16'h0001, 8'h03, 0);
        check_eq("f1_wr", bus.wr_out, 1);
        check_eq("f1_addr", bus.wr_addr_out, 8'h02);
        check_eq("f1_data", bus.data_out, 16'h0001);
        check_eq("f1_ok", ok_cnt, 16'd1);
        idle(1);
        check_eq("f1_wr_drop", bus.wr_out, 0);

        phase = "f2_badcsum";
        send_frame(8'h04, 16'h1234, 8'h00, 0);
        check_eq("f2_wr", bus.wr_out, 0);
        check_eq("f2_err", err_cnt, 16'd1);
        check_eq("f2_addr_kept", bus.wr_addr_out, 8'h02);
        check_eq("f2_data_kept", bus.data_out, 16'h0001);

        phase = "f3_resync";
        send(8'hEB);
        send_frame(8'h03, 16'h0055, 8'h58, 0);
        check_eq("f3_wr", bus.wr_out, 1);
        check_eq("f3_addr", bus.wr_addr_out, 8'h03);
        check_eq("f3_data", bus.data_out, 16'h0055);

        phase = "timeout";
        send(8'hEB); send(8'h90); send(8'h05);
        idle(Timeout - 1);
        check_eq("to_busy_before", busy, 1);
        idle(1);
        check_eq("to_busy_after", busy, 0);
        check_eq("to_err", err_cnt, 16'd2);
        check_eq("to_no_wr", bus.wr_addr_out, 8'h03);
        send_frame(8'h07, 16'h0102, 8'h0A, 0);
        check_eq("to_next_wr", bus.wr_out, 1);
        check_eq("to_next_addr", bus.wr_addr_out, 8'h07);

        phase = "reset_mid";
        send(8'hEB); send(8'h90); send(8'h06); send(8'h12);
        rst_n_in = 1'b0;
        #2;
        check_eq("reset_mid_outs", dut_vec(), 64'd0);
        model_reset();
        bus.byte_vld_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        send_frame(8'h06, 16'h1234, 8'h4C, 0);
        check_eq("f5_wr", bus.wr_out, 1);
        check_eq("f5_addr", bus.wr_addr_out, 8'h06);
        check_eq("f5_data", bus.data_out, 16'h1234);
        check_eq("f5_ok", ok_cnt, 16'd1);

        phase = "addr30";
        send_frame(8'h30, 16'h0000, 8'h30, 0);
        check_eq("addr30_wr", bus.wr_out, !AddrChk);

        phase = "addr_edges";
        edge_addr = '{8'h01, 8'h02, 8'h15, 8'h16};
        for (int i = 0; i < 4; i++) begin
            send_frame(edge_addr[i], 16'h0000, edge_addr[i], 1);
            check_eq("edge_wr", bus.wr_out, tb_addr_ok(edge_addr[i]));
        end

        // A byte landing on the would-be expiry edge keeps the frame alive.
        phase = "gap_limit";
        send(8'hEB); send(8'h90);
        idle(Timeout - 1);
        send(8'h11); send(8'h22); send(8'h33); send(8'h66);
        check_eq("gap_wr", bus.wr_out, 1);
        check_eq("gap_addr", bus.wr_addr_out, 8'h11);

        phase = "random";
        for (int i = 0; i < 300; i++) begin
            kind = int'($urandom_range(0, 9));
            a    = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 31)) : 8'($urandom);
            d    = 16'($urandom);
            cs   = a + d[15:8] + d[7:0];
            case (kind)
                6: send_frame(a, d, cs ^ 8'($urandom_range(1, 255)), 3);
                7: begin
                    send(8'hEB); send(8'h90);
                    for (int k = 0; k < int'($urandom_range(0, 3)); k++) send(8'($urandom));
                end
                8: for (int k = 0; k < int'($urandom_range(1, 4)); k++) send(8'($urandom));
                9: begin
                    send(8'hEB);
                    send_frame(a, d, cs, 2);
                end
                default: send_frame(a, d, cs, 3);
            endcase
            idle(int'($urandom_range(0, 3)));
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
